// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver: the transmit FSM
// state type, the default frame width, line levels, and a parity helper.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   DEFAULT_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL     = 1'b1;
  localparam logic START_LVL         = 1'b0;

  // Parity over up to 9 data bits. Callers zero-extend narrower data, which
  // does not change the XOR reduction. Even parity returns ^data, so the
  // total count of ones including the parity bit is even; odd inverts it.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// ---------------------------------------------------------------------------
// uart_transmitter_if
// Host write port of the UART transmitter.
//   wr_en   host -> tx   write strobe
//   din     host -> tx   byte to send
//   wr_rdy  tx -> host   holding register empty
//   overrun tx -> host   one-clk pulse when a write was dropped
// ---------------------------------------------------------------------------
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);

  logic                 wr_en;
  logic [DATA_BITS-1:0] din;
  logic                 wr_rdy;
  logic                 overrun;

  modport master (output wr_en, din, input wr_rdy, overrun);
  modport slave  (input wr_en, din, output wr_rdy, overrun);

endinterface

// File: rtl/uart_tx_hold.sv
// ---------------------------------------------------------------------------
// uart_tx_hold
// Single-entry holding register between the host and the shift register.
//   clk, rst_n     clock, async active-low reset
//   wr_en_i/din_i  host write; accepted only while empty
//   wr_rdy_o       empty flag (registered state)
//   overrun_o      one-clk pulse after a write arrived while full
//   pop_i          FSM consumes the entry
//   dout_o/full_o  stored byte and occupancy
// ---------------------------------------------------------------------------
module uart_tx_hold #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [DATA_BITS-1:0] din_i,
  output logic                 wr_rdy_o,
  output logic                 overrun_o,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] dout_o,
  output logic                 full_o
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 overrun_q, overrun_d;

  // Write and pop are mutually exclusive: a write needs the entry empty and
  // a pop needs it full, so no priority between them is required.
  always_comb begin
    full_d    = full_q;
    data_d    = data_q;
    overrun_d = wr_en_i && full_q;
    if (wr_en_i && !full_q) begin
      full_d = 1'b1;
      data_d = din_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign wr_rdy_o  = !full_q;
  assign overrun_o = overrun_q;
  assign dout_o    = data_q;
  assign full_o    = full_q;

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Serialises bytes onto a UART line: start bit, DATA_BITS data bits LSB
// first, optional parity bit, STOP_BITS stop bits. Every FSM step happens on
// a clken cycle, so each bit lasts exactly one clken period.
//   clk, rst_n  clock, async active-low reset
//   clken       one-clk pulse per bit period
//   wr          host write port (wr_en/din/wr_rdy/overrun)
//   tx          registered serial line, idles high
//   tx_busy     registered: frame in progress or byte pending
// ---------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clken,
  uart_transmitter_if.slave wr,
  output logic            tx,
  output logic            tx_busy
);

  localparam int   CNT_W     = $clog2(DATA_BITS);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
  logic                 stopCnt_q, stopCnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 holdPop;
  logic                 holdFull;
  logic [DATA_BITS-1:0] holdData;
  logic                 loadNext;
  logic                 holdFullNext;

  uart_tx_hold #(.DATA_BITS(DATA_BITS)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr.wr_en),
    .din_i    (wr.din),
    .wr_rdy_o (wr.wr_rdy),
    .overrun_o(wr.overrun),
    .pop_i    (holdPop),
    .dout_o   (holdData),
    .full_o   (holdFull)
  );

  // Next state. Loading from the holding register is shared by IDLE and the
  // last stop bit, which gives back-to-back frames without an idle bit.
  // tx and tx_busy are derived from the next state so that both registers
  // change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    parity_d  = parity_q;
    loadNext  = 1'b0;
    holdPop   = 1'b0;
    tx_d      = UART_IDLE_LVL;
    busy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clken && holdFull) loadNext = 1'b1;
      end
      START: begin
        if (clken) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (clken) begin
          shift_d  = shift_q >> 1;
          bitCnt_d = bitCnt_q + CNT_W'(1);
          if (bitCnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            stopCnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (clken) begin
          state_d   = STOP;
          stopCnt_d = 1'b0;
        end
      end
      STOP: begin
        if (clken) begin
          if (stopCnt_q == STOP_LAST) begin
            stopCnt_d = 1'b0;
            if (holdFull) loadNext = 1'b1;
            else          state_d  = IDLE;
          end else begin
            stopCnt_d = stopCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Parity is taken from the latched byte at load time, not from din.
    if (loadNext) begin
      holdPop  = 1'b1;
      shift_d  = holdData;
      parity_d = parity_bit(9'(holdData), PARITY_ODD != 0);
      state_d  = START;
    end

    unique case (state_d)
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = UART_IDLE_LVL;
    endcase

    holdFullNext = (holdFull && !holdPop) || (wr.wr_en && !holdFull);
    busy_d       = (state_d != IDLE) || holdFullNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule
